pc_fetch: RTL and testbench
===========================

# pc_fetch

Instruction-fetch front end for the single-cycle datapath. It owns the program-counter register and fetches the instruction at `pc` from instruction memory over a req/ack handshake. It presents `pc` and `instruction` to decode and to the branch/jump next-PC logic, and loads that logic's `newPC` result when the downstream stage consumes the current instruction.

## Interface
- `RESET_PC`, default 32'h00001000: PC value loaded on reset.
- `TIMEOUT_CYCLES`, default 255: maximum REQ-state cycles without `imem_ack` before the error state is entered. 0 disables the timeout.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `newPC`  in  32: next-PC from the branch/jump logic, sampled only on consume.
- `advance`  in  1: downstream accepts the current instruction. A consume occurs when `valid & advance`.
- `pc`  out  32: address of the instruction currently presented or being fetched.
- `instruction`  out  32: fetched instruction word, registered.
- `valid`  out  1: `instruction` corresponds to `pc`.
- `imem_addr`  out  32: memory address; always equals `pc`.
- `imem_req`  out  1: fetch request. High exactly while in REQ.
- `imem_ack`  in  1: memory returns `imem_rdata` this cycle.
- `imem_rdata`  in  32: instruction data, valid when `imem_ack` is high.
- `fetch_err`  out  1: sticky timeout flag.

## Operation
- FSM states: IDLE, REQ, HOLD, ERR. The reset state is IDLE.
- IDLE: moves to REQ on the next edge unconditionally.
- REQ: `imem_req`=1.
  - If `imem_ack`=1: capture `imem_rdata` into `instruction`, set `valid`=1, clear the wait counter, go to HOLD.
  - Else: increment the wait counter. If `TIMEOUT_CYCLES`≠0 and the counter reaches `TIMEOUT_CYCLES`, go to ERR and set `fetch_err`=1.
- HOLD: `valid`=1, `imem_req`=0, `instruction` stable.
  - If `advance`=1: `pc` ← {`newPC`[31:2], 2'b00}, `valid`←0, go to REQ.
  - Else remain in HOLD.
- ERR: `valid`=0, `imem_req`=0, `pc` frozen. Only `rst` exits this state.
- Width rules:
  - Misaligned `newPC` has bits [1:0] forced to zero. No fault is raised.
  - `pc` wraps naturally. `newPC`=32'hFFFFFFFC is legal.
  - Wait counter width is $clog2(TIMEOUT_CYCLES+1) and saturates; it never wraps.
- `imem_ack` is ignored outside REQ. A stray ack in HOLD or IDLE does not modify `instruction`.
- `advance` is ignored when `valid`=0.
- `pc` changes only on reset or on a consume.

## Timing
- Reset values: `pc`=`RESET_PC`, `imem_addr`=`RESET_PC`, `instruction`=0, `valid`=0, `imem_req`=0, `fetch_err`=0. Wait counter=0, state=IDLE.
- Reset is asynchronous. Asserting `rst` mid-REQ drops `imem_req` immediately, not at the next edge. An ack arriving after reset is ignored until the fresh REQ.
- First `imem_req` goes high at the first rising edge after `rst` deasserts.
- Zero-wait memory: ack is allowed in the first REQ cycle. `valid` then rises at the next edge.
- Fetch latency: N wait cycles give `valid` N+1 edges after REQ entry.
- Consume-to-next-valid, with zero-wait memory: 2 edges. Consume edge goes to REQ; ack edge goes to HOLD.
- `imem_addr` is stable for the entire REQ interval. The memory may sample it on any REQ cycle.
- Timeout: with `TIMEOUT_CYCLES`=T and no ack, ERR is entered at the T-th REQ edge. If ack coincides with that edge, ack wins and the FSM goes to HOLD.

## Test plan
- Reset and first fetch:
  - Release `rst`. Expect `imem_req`=1 with `imem_addr`=32'h00001000 one edge later.
  - Ack with rdata 32'h8C220004. Expect `valid`=1 and `instruction`=32'h8C220004 at the next edge.
- Sequential consume with zero-wait memory:
  - Hold `advance`=1 and set `newPC`=`pc`+4.
  - Expect fetches at 0x1000, 0x1004, 0x1008. Each `valid` pulse lasts 1 cycle, spaced 2 edges apart.
- Jump with misaligned target:
  - In HOLD, drive `newPC`=32'h00002003 with `advance`=1.
  - Expect next `imem_addr`=32'h00002000. Expect `instruction` unchanged until the ack.
- Wait states and stray ack:
  - Ack after 3 wait cycles. Expect `valid` at the 4th edge after REQ entry.
  - Drive a stray ack in HOLD with rdata 32'hDEADBEEF. Expect `instruction` unchanged.
- Timeout, ack race and reset:
  - With `TIMEOUT_CYCLES`=4 and no ack, expect `fetch_err`=1 and `imem_req`=0 after 4 REQ edges.
  - Repeat with the ack on the 4th edge: expect HOLD and `fetch_err`=0.
  - Assert `rst` mid-REQ: expect immediate return to all reset values.

Source files
------------

// File: rtl/pc_fetch.sv
// Fetch front end: owns pc and fetches over imem req/ack; valid one edge after ack, next fetch on consume.
// Holds the instruction (HOLD) until advance; stalls in REQ on slow memory, latches ERR on timeout.
module pc_fetch #(
  parameter logic [31:0] RESET_PC       = 32'h00001000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] newPC,
  input  logic        advance,
  output logic [31:0] pc,
  output logic [31:0] instruction,
  output logic        valid,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        fetch_err
);

  localparam int CW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] T_LIM = CW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, ERR} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] wait_cnt, wait_inc;
  logic          consume, timeout;

  // Saturating increment: the counter never wraps back below the limit.
  assign wait_inc = (wait_cnt == {CW{1'b1}}) ? wait_cnt : wait_cnt + CW'(1);
  assign timeout  = (TIMEOUT_CYCLES != 0) && (wait_inc == T_LIM);
  assign consume  = (state == HOLD) && advance;
  assign imem_addr = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = REQ;
      REQ: begin
        if (imem_ack)     state_nxt = HOLD;
        else if (timeout) state_nxt = ERR;
      end
      HOLD: if (advance) state_nxt = REQ;
      ERR:  state_nxt = ERR;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decode the registered state only, so reset drops imem_req immediately.
  always_comb begin
    imem_req  = 1'b0;
    valid     = 1'b0;
    fetch_err = 1'b0;
    case (state)
      REQ:  imem_req  = 1'b1;
      HOLD: valid     = 1'b1;
      ERR:  fetch_err = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      instruction <= '0;
      wait_cnt    <= '0;
    end else begin
      if (consume)
        pc <= newPC & 32'hFFFF_FFFC;
      if (state == REQ) begin
        if (imem_ack) begin
          instruction <= imem_rdata;
          wait_cnt    <= '0;
        end else begin
          wait_cnt    <= wait_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: stimulus pushes expected {pc, instruction} per ack,
// a negedge monitor pops and compares on every rising valid.
module tb_pc_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] newPC;
  logic        advance;
  logic [31:0] pc, instruction, imem_addr, imem_rdata;
  logic        valid, imem_req, imem_ack, fetch_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [63:0] sb[$];

  pc_fetch #(.RESET_PC(32'h00001000), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .newPC(newPC), .advance(advance),
    .pc(pc), .instruction(instruction), .valid(valid),
    .imem_addr(imem_addr), .imem_req(imem_req), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every new valid must match the oldest outstanding expected fetch.
  logic prev_v = 1'b0;
  always @(negedge clk) begin
    logic [63:0] e;
    if (valid === 1'b1 && prev_v !== 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: valid with pc %h instr %h, expected none", pc, instruction);
      end else begin
        e = sb.pop_front();
        chk("sb_pc", pc, e[63:32]);
        chk("sb_instr", instruction, e[31:0]);
      end
    end
    prev_v = valid;
  end

  task automatic step;
    @(negedge clk);
  endtask

  // Called at a negedge while in REQ; returns at the negedge after the ack edge.
  task automatic serve(input int waits, input logic [31:0] addr, input logic [31:0] data);
    for (int i = 0; i < waits; i++) begin
      chk("wait_req", {31'b0, imem_req}, 32'd1);
      chk("wait_addr", imem_addr, addr);
      step();
    end
    chk("ack_req", {31'b0, imem_req}, 32'd1);
    chk("ack_addr", imem_addr, addr);
    chk("ack_valid_lo", {31'b0, valid}, 32'd0);
    imem_ack = 1'b1;
    imem_rdata = data;
    sb.push_back({addr, data});
    step();
    imem_ack = 1'b0;
    imem_rdata = 32'h0;
    chk("hold_valid", {31'b0, valid}, 32'd1);
    chk("hold_req", {31'b0, imem_req}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int last_v, entry;
    logic [31:0] exp_pc;
    rst = 1'b1; advance = 1'b0; newPC = 32'h0; imem_ack = 1'b0; imem_rdata = 32'h0;
    repeat (2) step();
    chk("rst_pc", pc, 32'h00001000);
    chk("rst_addr", imem_addr, 32'h00001000);
    chk("rst_instr", instruction, 32'h0);
    chk("rst_valid", {31'b0, valid}, 32'd0);
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_err", {31'b0, fetch_err}, 32'd0);

    rst = 1'b0;
    #1 chk("idle_req", {31'b0, imem_req}, 32'd0);
    step();
    chk("first_req", {31'b0, imem_req}, 32'd1);
    serve(0, 32'h00001000, 32'h8C220004);
    chk("first_instr", instruction, 32'h8C220004);
    last_v = cyc;

    // Sequential zero-wait consumes with advance held high.
    exp_pc = 32'h00001000;
    for (int k = 0; k < 2; k++) begin
      advance = 1'b1;
      newPC = exp_pc + 32'd4;
      exp_pc = exp_pc + 32'd4;
      step();
      chk("seq_valid_lo", {31'b0, valid}, 32'd0);
      serve(0, exp_pc, (k == 0) ? 32'h00430820 : 32'h10000003);
      chk("seq_spacing", cyc - last_v, 32'd2);
      last_v = cyc;
    end
    advance = 1'b0;
    step();
    chk("hold_stable", {31'b0, valid}, 32'd1);
    chk("hold_pc", pc, 32'h00001008);

    // Misaligned jump, then 3 wait states.
    advance = 1'b1;
    newPC = 32'h00002003;
    step();
    advance = 1'b0;
    entry = cyc;
    chk("jump_addr", imem_addr, 32'h00002000);
    chk("jump_instr_kept", instruction, 32'h10000003);
    serve(3, 32'h00002000, 32'h24010005);
    chk("wait_latency", cyc - entry, 32'd4);

    // Stray ack in HOLD must not disturb the instruction.
    imem_ack = 1'b1;
    imem_rdata = 32'hDEADBEEF;
    step();
    imem_ack = 1'b0;
    chk("stray_instr", instruction, 32'h24010005);
    chk("stray_valid", {31'b0, valid}, 32'd1);

    // Ack on the 4th REQ edge beats the timeout.
    advance = 1'b1;
    newPC = 32'h00003000;
    step();
    advance = 1'b0;
    serve(3, 32'h00003000, 32'hAC010008);
    chk("race_err", {31'b0, fetch_err}, 32'd0);

    // No ack: ERR on the 4th REQ edge.
    advance = 1'b1;
    newPC = 32'h00004000;
    step();
    advance = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("to_pending_err", {31'b0, fetch_err}, 32'd0);
      step();
    end
    chk("to_err", {31'b0, fetch_err}, 32'd1);
    chk("to_req", {31'b0, imem_req}, 32'd0);
    chk("to_valid", {31'b0, valid}, 32'd0);
    imem_ack = 1'b1;
    advance = 1'b1;
    repeat (3) step();
    imem_ack = 1'b0;
    advance = 1'b0;
    chk("err_sticky", {31'b0, fetch_err}, 32'd1);
    chk("err_pc_frozen", pc, 32'h00004000);

    // Leave ERR, then reset asynchronously in the middle of REQ.
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("re_req", {31'b0, imem_req}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_req", {31'b0, imem_req}, 32'd0);
    chk("arst_err", {31'b0, fetch_err}, 32'd0);
    chk("arst_pc", pc, 32'h00001000);
    step();
    imem_ack = 1'b1;
    imem_rdata = 32'hBAD0BAD0;
    rst = 1'b0;
    step();
    imem_ack = 1'b0;
    chk("post_rst_valid", {31'b0, valid}, 32'd0);
    chk("post_rst_instr", instruction, 32'h0);
    serve(0, 32'h00001000, 32'h00000013);

    repeat (2) step();
    chk("sb_drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
